// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the uart_tx arbiter slice: frame size, FSM states,
// and the index-width helper used by the arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

    // start + 8 data + stop
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans requesters starting just after the
// last winner and returns the first active one as one-hot, index and any-flag.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First active request in order last+1, last+2, ..., last (mod N).
    always_comb begin
        int unsigned k;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            k = (32'(last) + i) % N;
            if (!any && req[k[IW-1:0]]) begin
                any                = 1'b1;
                grant[k[IW-1:0]]   = 1'b1;
                idx                = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// uart_tx has no busy flag, so frames are paced here with a hold counter.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned CLOCKS_PER_BAUD = 104,
    parameter int unsigned FRAME_BITS      = UART_FRAME_BITS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [8*NUM_REQ-1:0]         req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         write_o,
    output logic [7:0]                   data_o,
    output logic                         busy_o,
    output logic [idx_width(NUM_REQ)-1:0] grant_id_o
);

    localparam int unsigned FRAME_CLOCKS = FRAME_BITS * CLOCKS_PER_BAUD;
    localparam int unsigned CW           = $clog2(FRAME_CLOCKS);
    localparam int unsigned GW           = idx_width(NUM_REQ);

    localparam logic [CW-1:0] CNT_RESET  = CW'(FRAME_CLOCKS - 1);
    // LAUNCH is already the first clock of the frame, so HOLD reloads one
    // short; writes then land exactly FRAME_CLOCKS+1 cycles apart.
    localparam logic [CW-1:0] CNT_LAUNCH = CW'(FRAME_CLOCKS - 2);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [NUM_REQ-1:0] pick_grant;
    logic [GW-1:0]   pick_idx;
    logic            pick_any;
    logic [7:0]      sel_data;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_pick (
        .req   (req_valid_i),
        .last  (grant_id_o),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Byte of the current winner, selected by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) begin
                sel_data = req_data_i[8*k +: 8];
            end
        end
    end

    // State register; reset lands in HOLD so an in-flight frame can finish.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the state-decoded outputs (ready, write, busy).
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        write_o     = 1'b0;
        busy_o      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (pick_any) begin
                    req_ready_o = pick_grant;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                write_o = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Frame pacing counter: reloaded at launch, counts down through HOLD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_RESET;
        end else if (state_q == ST_LAUNCH) begin
            cnt_q <= CNT_LAUNCH;
        end else if (state_q == ST_HOLD && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Capture the accepted byte and the winner index on acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_o     <= '0;
            grant_id_o <= GW'(NUM_REQ - 1);
        end else if (state_q == ST_IDLE && pick_any) begin
            data_o     <= sel_data;
            grant_id_o <= pick_idx;
        end
    end

endmodule
